// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// ten's-complement subtract, invalid-digit flag, start/busy/done handshake.
module bcd_serial_addsub #(
  parameter int N_DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  SUB,
  input  logic [4*N_DIGITS-1:0] A,
  input  logic [4*N_DIGITS-1:0] B,
  output logic [4*N_DIGITS-1:0] S,
  output logic                  COUT,
  output logic                  ERR,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int W  = 4 * N_DIGITS;
  localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One BCD digit step; returns {carry_out, digit}. Subtract uses nine's complement of b.
  function automatic logic [4:0] bcd_digit_step(input logic [3:0] a, input logic [3:0] b,
                                                input logic sub, input logic c);
    logic [3:0] bp;
    logic [4:0] t;
    logic [4:0] adj;
    logic [4:0] r;
    bp  = sub ? (4'd9 - b) : b;
    t   = {1'b0, a} + {1'b0, bp} + {4'd0, c};
    adj = t + 5'd6;
    if (t > 5'd9) begin
      r = {1'b1, adj[3:0]};
    end else begin
      r = {1'b0, t[3:0]};
    end
    return r;
  endfunction

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  state_t        state_r;
  state_t        state_nxt_s;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          sub_r;
  logic          carry_r;
  logic [CW-1:0] cnt_r;
  logic [4:0]    dig_s;
  logic          last_s;
  logic [W-1:0]  s_nxt_s;

  // Operands shift right each digit so the current digit is always in the low nibble.
  assign dig_s  = bcd_digit_step(a_r[3:0], b_r[3:0], sub_r, carry_r);
  assign last_s = (cnt_r == CW'(N_DIGITS - 1));

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Result with digit cnt_r replaced by the freshly computed digit.
  always_comb begin
    s_nxt_s = S;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (cnt_r == CW'(i)) begin
        s_nxt_s[4*i +: 4] = dig_s[3:0];
      end else begin
        s_nxt_s[4*i +: 4] = S[4*i +: 4];
      end
    end
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      sub_r   <= 1'b0;
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      S       <= {W{1'b0}};
      COUT    <= 1'b0;
      ERR     <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      BUSY <= (state_nxt_s == ST_RUN);
      DONE <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            a_r     <= A;
            b_r     <= B;
            sub_r   <= SUB;
            carry_r <= SUB;
            cnt_r   <= {CW{1'b0}};
            S       <= {W{1'b0}};
            ERR     <= has_bad_digit(A) | has_bad_digit(B);
          end
        end
        ST_RUN: begin
          a_r     <= a_r >> 3'd4;
          b_r     <= b_r >> 3'd4;
          carry_r <= dig_s[4];
          S       <= s_nxt_s;
          if (last_s) begin
            cnt_r <= {CW{1'b0}};
            COUT  <= dig_s[4];
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          cnt_r <= {CW{1'b0}};
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed vector bench for bcd_serial_addsub (N=4 main instance, N=1 corner instance).
module tb_bcd_serial_addsub;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        SUB = 1'b0;
  logic [15:0] A = 16'h0;
  logic [15:0] B = 16'h0;
  logic [15:0] S;
  logic        COUT, ERR, BUSY, DONE;

  logic        START1 = 1'b0;
  logic        SUB1 = 1'b0;
  logic [3:0]  A1 = 4'h0;
  logic [3:0]  B1 = 4'h0;
  logic [3:0]  S1;
  logic        COUT1, ERR1, BUSY1, DONE1;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  bcd_serial_addsub #(.N_DIGITS(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SUB(SUB), .A(A), .B(B),
    .S(S), .COUT(COUT), .ERR(ERR), .BUSY(BUSY), .DONE(DONE)
  );

  bcd_serial_addsub #(.N_DIGITS(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START1), .SUB(SUB1), .A(A1), .B(B1),
    .S(S1), .COUT(COUT1), .ERR(ERR1), .BUSY(BUSY1), .DONE(DONE1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        err;
    logic        chk_s;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one operation; returns at the negedge where DONE is seen (or after a bound).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       output int lat, output int busyc);
    @(negedge CLK);
    A = a; B = b; SUB = sub; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    lat = 1;
    busyc = 0;
    while (!DONE && lat < 20) begin
      if (BUSY) busyc++;
      @(negedge CLK);
      lat++;
    end
  endtask

  initial begin
    int lat, busyc, ndone, first_done;
    logic busy_e6;
    logic [15:0] s_hold;

    vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{16'h1234, 16'h5000, 1'b1, 16'h6234, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{16'h4321, 16'h4321, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{16'h0000, 16'h0001, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{16'h9999, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

    #12;
    chk("reset_s", S, 16'h0);
    chk("reset_cout", COUT, 1'b0);
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_done", DONE, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat, busyc);
      chk($sformatf("v%0d_latency", i), lat, 5);
      chk($sformatf("v%0d_busy_cycles", i), busyc, 4);
      if (vecs[i].chk_s) begin
        chk($sformatf("v%0d_s", i), S, vecs[i].s);
        chk($sformatf("v%0d_cout", i), COUT, vecs[i].cout);
      end
      chk($sformatf("v%0d_err", i), ERR, vecs[i].err);
      s_hold = S;
      @(negedge CLK);
      chk($sformatf("v%0d_done_pulse", i), DONE, 1'b0);
      @(negedge CLK);
      chk($sformatf("v%0d_hold_s", i), S, s_hold);
      chk($sformatf("v%0d_hold_err", i), ERR, vecs[i].err);
    end

    // START held high for 8 edges: one DONE, re-accept on first IDLE cycle after DONE.
    @(negedge CLK);
    A = 16'h1111; B = 16'h2222; SUB = 1'b0; START = 1'b1;
    ndone = 0; first_done = -1; busy_e6 = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(negedge CLK);
      if (DONE) begin
        ndone++;
        if (first_done < 0) first_done = e;
      end
      if (e == 6) busy_e6 = BUSY;
    end
    START = 1'b0;
    A = 16'h9999; B = 16'h9999; SUB = 1'b1;
    chk("hs_done_count", ndone, 1);
    chk("hs_done_edge", first_done, 4);
    chk("hs_reaccept_busy", busy_e6, 1'b1);
    lat = 0;
    while (!DONE && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    chk("hs_second_done_seen", DONE, 1'b1);
    chk("hs_second_s", S, 16'h3333);
    chk("hs_second_cout", COUT, 1'b0);

    // Reset in the middle of an operation.
    @(negedge CLK);
    A = 16'h1234; B = 16'h5678; SUB = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("rst_mid_s", S, 16'h0);
    chk("rst_mid_cout", COUT, 1'b0);
    chk("rst_mid_busy", BUSY, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    ndone = 0;
    for (int e = 0; e < 8; e++) begin
      @(negedge CLK);
      if (DONE || BUSY) ndone++;
    end
    chk("rst_mid_no_done", ndone, 0);
    do_op(16'h1234, 16'h5678, 1'b0, lat, busyc);
    chk("rst_after_latency", lat, 5);
    chk("rst_after_s", S, 16'h6912);

    // Single-digit instance: completes at E1, DONE in cycle 2.
    @(negedge CLK);
    A1 = 4'd7; B1 = 4'd5; SUB1 = 1'b0; START1 = 1'b1;
    @(negedge CLK);
    START1 = 1'b0;
    chk("n1_busy", BUSY1, 1'b1);
    chk("n1_done_early", DONE1, 1'b0);
    @(negedge CLK);
    chk("n1_done", DONE1, 1'b1);
    chk("n1_s", S1, 4'd2);
    chk("n1_cout", COUT1, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    A1 = 4'd3; B1 = 4'd5; SUB1 = 1'b1; START1 = 1'b1;
    @(negedge CLK);
    START1 = 1'b0;
    @(negedge CLK);
    chk("n1_sub_done", DONE1, 1'b1);
    chk("n1_sub_s", S1, 4'd8);
    chk("n1_sub_cout", COUT1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Multi-digit packed-BCD adder/subtractor for the ALU datapath.
- Processes one decimal digit per clock, least significant digit first, with a registered decimal carry between digits.
- Start/busy/done handshake; the result is held until the next accepted operation.
- Generalises the single-bit full adder to N digits and adds a subtract mode (ten's complement) and invalid-digit detection.

Parameters:
- N_DIGITS, default 4: number of BCD digits per operand; minimum 1.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous reset, active-high.
- START  in  1  request; sampled only in IDLE.
- SUB  in  1  mode, latched at START: 0 = A+B, 1 = A-B.
- A  in  4*N_DIGITS  packed BCD operand; digit 0 is bits [3:0].
- B  in  4*N_DIGITS  packed BCD operand; same layout as A.
- S  out  4*N_DIGITS  packed BCD result.
- COUT  out  1  add: decimal carry out. Sub: 1 = no borrow (A>=B).
- ERR  out  1  an operand digit >9 was present at START.
- BUSY  out  1  high while digits are being processed.
- DONE  out  1  one-cycle pulse; S, COUT and ERR are valid.

Behaviour:
- Interface: one clock (CLK); reset RST is asynchronous, active-high.
- Reset: state=IDLE. S=0, COUT=0, ERR=0, BUSY=0, DONE=0, digit counter=0, carry register=0. All are registered outputs.
- States:
  - IDLE: START=1 at edge E0 latches A, B and SUB into internal registers, clears S to 0, sets carry register=SUB and counter=0, and goes to RUN (BUSY=1 after E0). START=0 stays in IDLE.
  - RUN: on each of edges E1..EN, process digit k=counter, write S digit k, update the carry register, increment the counter. At EN (k=N_DIGITS-1), COUT=final carry, go to DONE, BUSY=0.
  - DONE: DONE=1 for exactly this cycle. Next edge returns to IDLE, DONE=0.
- Latency: START edge to DONE high = N_DIGITS+1 edges; throughput is one operation per N_DIGITS+2 cycles.
- START in RUN or DONE: ignored, no queueing. Operand changes after E0 have no effect.
- Per-digit arithmetic (5-bit intermediate):
  - b' = SUB ? (9 - b) : b.
  - t = a + b' + c.
  - If t > 9: digit = (t + 6)[3:0], c = 1.
  - Else: digit = t[3:0], c = 0.
- Subtract:
  - A >= B: S = A-B, COUT=1.
  - A < B: S = 10^N - (B-A) (ten's complement), COUT=0.
- ERR: set at E0 if any nibble of A or B is >9, else cleared at E0. The operation still runs with the same arithmetic; S is then unspecified but deterministic. ERR is held until the next accepted START.
- Hold: S, COUT and ERR keep their values from DONE through IDLE until the next START. During RUN, S shows partially written digits and bench checks are not allowed.
- Reset mid-operation: immediate return to reset values, no DONE pulse, latched operands discarded.
- N_DIGITS=1: counter is 1 bit wide. Operation completes at E1, DONE is high in cycle 2.

Test Plan:
- Add, N=4: A=0x1234, B=0x5678, SUB=0 -> BUSY=1 for 4 cycles, then DONE pulse 5 edges after START, S=0x6912, COUT=0, ERR=0.
- Carry ripple: A=0x9999, B=0x0001, SUB=0 -> S=0x0000, COUT=1. Also A=0x9999, B=0x9999 -> S=0x9998, COUT=1.
- Subtract: A=0x5000, B=0x1234, SUB=1 -> S=0x3766, COUT=1. Then A=0x1234, B=0x5000, SUB=1 -> S=0x6234, COUT=0. Then A=B=0x4321, SUB=1 -> S=0x0000, COUT=1.
- Handshake: START held high for 8 cycles -> exactly one operation, with DONE on edge 5. Second START accepted on the first IDLE cycle after DONE. Operands changed during RUN do not affect S.
- Invalid digit: A=0x00A0, B=0x0001 -> ERR=1 at DONE. Following valid op A=0x0001, B=0x0001 -> ERR=0, S=0x0002.
- Reset mid-op: START with A=0x1234, B=0x5678, assert RST after edge 2 -> S=0, COUT=0, BUSY=0 immediately. No DONE pulse. A new op after release completes normally.
